// File: rtl/encoder_regs_pkg.sv
// ============================================================================
// encoder_regs_pkg : shared types and constants for the encoder register block
// Rev 1.0
// ============================================================================
`default_nettype none

package encoder_regs_pkg;

  localparam int NUM_REGS  = 4;
  localparam int REG_IDX_W = 2;

  localparam logic [1:0] OKAY = 2'b00;

  localparam logic [3:0] ENC_REG0 = 4'h0;
  localparam logic [3:0] ENC_REG1 = 4'h4;
  localparam logic [3:0] ENC_REG2 = 4'h8;
  localparam logic [3:0] ENC_REG3 = 4'hC;

  typedef enum logic [0:0] {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_t;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  typedef logic [NUM_REGS-1:0][31:0] reg_file_t;

endpackage

`default_nettype wire

// File: rtl/encoder_axil_regs.sv
// ============================================================================
// encoder_axil_regs : AXI4-Lite responder for the encoder's four control regs
// Rev 1.0
// ============================================================================
`default_nettype none

module encoder_axil_regs
  import encoder_regs_pkg::*;
#(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 4,
  parameter logic [31:0] C_RESET_VAL        = 32'h0
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
  input  logic [2:0]                        s00_axi_awprot,
  input  logic                              s00_axi_awvalid,
  output logic                              s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
  input  logic                              s00_axi_wvalid,
  output logic                              s00_axi_wready,
  output logic [1:0]                        s00_axi_bresp,
  output logic                              s00_axi_bvalid,
  input  logic                              s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
  input  logic [2:0]                        s00_axi_arprot,
  input  logic                              s00_axi_arvalid,
  output logic                              s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
  output logic [1:0]                        s00_axi_rresp,
  output logic                              s00_axi_rvalid,
  input  logic                              s00_axi_rready,
  output logic [NUM_REGS-1:0][C_S_AXI_DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]               reg_wr_pulse
);

  localparam int NUM_BYTES = C_S_AXI_DATA_WIDTH / 8;

  wr_state_t                     wr_state_q, wr_state_d;
  rd_state_t                     rd_state_q, rd_state_d;
  logic                          awready_q, awready_d;
  logic                          wready_q, wready_d;
  logic                          bvalid_q, bvalid_d;
  logic                          arready_q, arready_d;
  logic                          rvalid_q, rvalid_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                          aw_held_q, aw_held_d;
  logic                          w_held_q, w_held_d;
  logic [REG_IDX_W-1:0]          wr_idx_q, wr_idx_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [NUM_BYTES-1:0]          wstrb_q, wstrb_d;
  reg_file_t                     regs_q, regs_d;
  logic [NUM_REGS-1:0]           wr_pulse_d, wr_pulse_q;

  logic aw_hs, w_hs, ar_hs;
  logic unused_inputs;

  assign aw_hs = s00_axi_awvalid & awready_q;
  assign w_hs  = s00_axi_wvalid  & wready_q;
  assign ar_hs = s00_axi_arvalid & arready_q;

  assign unused_inputs = ^{s00_axi_awprot, s00_axi_arprot,
                           s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  // Write channel: AW and W are latched independently; commit once both are held.
  always_comb begin
    wr_state_d = wr_state_q;
    awready_d  = awready_q;
    wready_d   = wready_q;
    bvalid_d   = bvalid_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    wr_idx_d   = wr_idx_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    regs_d     = regs_q;
    wr_pulse_d = '0;
    case (wr_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          wr_idx_d  = s00_axi_awaddr[REG_IDX_W+1:2];
          aw_held_d = 1'b1;
        end
        if (w_hs) begin
          wdata_d  = s00_axi_wdata;
          wstrb_d  = s00_axi_wstrb;
          w_held_d = 1'b1;
        end
        if (aw_held_d && w_held_d) begin
          for (int k = 0; k < NUM_BYTES; k++) begin
            if (wstrb_d[k]) regs_d[wr_idx_d][8*k +: 8] = wdata_d[8*k +: 8];
          end
          wr_pulse_d[wr_idx_d] = 1'b1;
          bvalid_d   = 1'b1;
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
          awready_d  = 1'b0;
          wready_d   = 1'b0;
          wr_state_d = W_RESP;
        end else begin
          awready_d = ~aw_held_d;
          wready_d  = ~w_held_d;
        end
      end
      W_RESP: begin
        if (s00_axi_bready) begin
          bvalid_d   = 1'b0;
          awready_d  = 1'b1;
          wready_d   = 1'b1;
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  // Read samples regs_q, so a same-cycle write is not yet visible.
  always_comb begin
    rd_state_d = rd_state_q;
    arready_d  = arready_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    case (rd_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          rdata_d    = regs_q[s00_axi_araddr[REG_IDX_W+1:2]];
          rvalid_d   = 1'b1;
          arready_d  = 1'b0;
          rd_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (s00_axi_rready) begin
          rvalid_d   = 1'b0;
          arready_d  = 1'b1;
          rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      wr_state_q <= W_IDLE;
      rd_state_q <= R_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      wr_idx_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      regs_q     <= {NUM_REGS{C_RESET_VAL}};
      wr_pulse_q <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      wr_idx_q   <= wr_idx_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      regs_q     <= regs_d;
      wr_pulse_q <= wr_pulse_d;
    end
  end

  assign s00_axi_awready = awready_q;
  assign s00_axi_wready  = wready_q;
  assign s00_axi_bvalid  = bvalid_q;
  assign s00_axi_bresp   = OKAY;
  assign s00_axi_arready = arready_q;
  assign s00_axi_rvalid  = rvalid_q;
  assign s00_axi_rdata   = rdata_q;
  assign s00_axi_rresp   = OKAY;
  assign reg_q           = regs_q;
  assign reg_wr_pulse    = wr_pulse_q;

endmodule

`default_nettype wire

// File: tb/tb_encoder_axil_regs.sv
// ============================================================================
// tb_encoder_axil_regs : directed self-checking bench for encoder_axil_regs
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_encoder_axil_regs;
  import encoder_regs_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3:0]       awaddr = '0;
  logic [2:0]       awprot = '0;
  logic             awvalid = 1'b0;
  logic             awready;
  logic [31:0]      wdata = '0;
  logic [3:0]       wstrb = '0;
  logic             wvalid = 1'b0;
  logic             wready;
  logic [1:0]       bresp;
  logic             bvalid;
  logic             bready = 1'b0;
  logic [3:0]       araddr = '0;
  logic [2:0]       arprot = '0;
  logic             arvalid = 1'b0;
  logic             arready;
  logic [31:0]      rdata;
  logic [1:0]       rresp;
  logic             rvalid;
  logic             rready = 1'b0;
  logic [3:0][31:0] reg_q;
  logic [3:0]       reg_wr_pulse;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] rd;
  logic [3:0]  last_pulse;

  always #5 clk = ~clk;

  encoder_axil_regs #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(4),
    .C_RESET_VAL       (32'h0)
  ) dut (
    .s00_axi_aclk   (clk),
    .s00_axi_areset (rst),
    .s00_axi_awaddr (awaddr),
    .s00_axi_awprot (awprot),
    .s00_axi_awvalid(awvalid),
    .s00_axi_awready(awready),
    .s00_axi_wdata  (wdata),
    .s00_axi_wstrb  (wstrb),
    .s00_axi_wvalid (wvalid),
    .s00_axi_wready (wready),
    .s00_axi_bresp  (bresp),
    .s00_axi_bvalid (bvalid),
    .s00_axi_bready (bready),
    .s00_axi_araddr (araddr),
    .s00_axi_arprot (arprot),
    .s00_axi_arvalid(arvalid),
    .s00_axi_arready(arready),
    .s00_axi_rdata  (rdata),
    .s00_axi_rresp  (rresp),
    .s00_axi_rvalid (rvalid),
    .s00_axi_rready (rready),
    .reg_q          (reg_q),
    .reg_wr_pulse   (reg_wr_pulse)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic ok, aw_acc, w_acc;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0; ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      aw_acc = awvalid && awready;
      w_acc  = wvalid && wready;
      @(negedge clk);
      if (aw_acc) awvalid = 1'b0;
      if (w_acc)  wvalid  = 1'b0;
      if (!awvalid && !wvalid) begin ok = 1'b1; break; end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    check("wr_accept", {31'b0, ok}, 32'd1);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bvalid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("wr_bvalid", {31'b0, ok}, 32'd1);
    check("wr_bresp", {30'b0, bresp}, 32'd0);
    last_pulse = reg_wr_pulse;
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
    logic ok;
    araddr = addr; arvalid = 1'b1; rready = 1'b0; ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (arready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    arvalid = 1'b0;
    check("rd_accept", {31'b0, ok}, 32'd1);
    check("rd_latency", {31'b0, rvalid}, 32'd1);
    check("rd_rresp", {30'b0, rresp}, 32'd0);
    data = rdata;
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  // One half arrives first, the partner three cycles later.
  task automatic split_write(input logic [3:0] addr, input logic [31:0] data, input logic aw_first);
    bready = 1'b0;
    awaddr = addr; wdata = data; wstrb = 4'hF;
    if (aw_first) awvalid = 1'b1; else wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    check("split_first_rdy", {31'b0, aw_first ? awready : wready}, 32'd0);
    check("split_other_rdy", {31'b0, aw_first ? wready : awready}, 32'd1);
    repeat (2) @(negedge clk);
    check("split_no_pulse", {28'b0, reg_wr_pulse}, 32'd0);
    check("split_no_bvalid", {31'b0, bvalid}, 32'd0);
    if (aw_first) wvalid = 1'b1; else awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    check("split_pulse", {28'b0, reg_wr_pulse}, 32'd1 << addr[3:2]);
    check("split_bvalid", {31'b0, bvalid}, 32'd1);
    @(negedge clk);
    check("split_pulse_gone", {28'b0, reg_wr_pulse}, 32'd0);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check("split_bvalid_gone", {31'b0, bvalid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_awready", {31'b0, awready}, 32'd0);
    check("rst_wready", {31'b0, wready}, 32'd0);
    check("rst_arready", {31'b0, arready}, 32'd0);
    check("rst_bvalid", {31'b0, bvalid}, 32'd0);
    check("rst_rvalid", {31'b0, rvalid}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_pulse", {28'b0, reg_wr_pulse}, 32'd0);
    for (int i = 0; i < 4; i++) check("rst_reg", reg_q[i], 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_awready", {31'b0, awready}, 32'd1);
    check("idle_arready", {31'b0, arready}, 32'd1);

    // Basic write/readback across all four registers
    axi_write(ENC_REG0, 32'd1, 4'hF); check("t1_pulse0", {28'b0, last_pulse}, 32'h1);
    axi_write(ENC_REG1, 32'd2, 4'hF); check("t1_pulse1", {28'b0, last_pulse}, 32'h2);
    axi_write(ENC_REG2, 32'd3, 4'hF); check("t1_pulse2", {28'b0, last_pulse}, 32'h4);
    axi_write(ENC_REG3, 32'd4, 4'hF); check("t1_pulse3", {28'b0, last_pulse}, 32'h8);
    axi_read(ENC_REG0, rd); check("t1_rd0", rd, 32'd1);
    axi_read(ENC_REG1, rd); check("t1_rd1", rd, 32'd2);
    axi_read(ENC_REG2, rd); check("t1_rd2", rd, 32'd3);
    axi_read(ENC_REG3, rd); check("t1_rd3", rd, 32'd4);

    // Byte enables
    axi_write(ENC_REG1, 32'hAABBCCDD, 4'hF);
    axi_write(ENC_REG1, 32'h11223344, 4'b0101);
    axi_read(ENC_REG1, rd); check("t3_strb", rd, 32'hAA22CC44);
    axi_read(4'h5, rd); check("t3_alias", rd, 32'hAA22CC44);

    // AW before W, then W before AW
    split_write(ENC_REG2, 32'h55, 1'b1);
    split_write(ENC_REG3, 32'h66, 1'b0);
    axi_read(ENC_REG2, rd); check("t2_rd2", rd, 32'h55);
    axi_read(ENC_REG3, rd); check("t2_rd3", rd, 32'h66);

    // Empty strobe still pulses but leaves data untouched
    axi_write(ENC_REG3, 32'hFFFFFFFF, 4'h0);
    check("strb0_pulse", {28'b0, last_pulse}, 32'h8);
    axi_read(ENC_REG3, rd); check("strb0_data", rd, 32'h66);

    // Write response backpressure; a second write must not be taken
    awaddr = ENC_REG0; wdata = 32'h0A0A; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(negedge clk);
    check("t4_bvalid", {31'b0, bvalid}, 32'd1);
    wdata = 32'hDEADBEEF;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t4_bhold", {31'b0, bvalid}, 32'd1);
      check("t4_awready", {31'b0, awready}, 32'd0);
    end
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check("t4_bvalid_gone", {31'b0, bvalid}, 32'd0);
    axi_read(ENC_REG0, rd); check("t4_no_second", rd, 32'h0A0A);

    // Read data backpressure
    araddr = ENC_REG1; arvalid = 1'b1; rready = 1'b0;
    @(negedge clk);
    arvalid = 1'b0;
    check("t4_rvalid", {31'b0, rvalid}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t4_rhold", {31'b0, rvalid}, 32'd1);
      check("t4_rdata_stable", rdata, 32'hAA22CC44);
      check("t4_arready", {31'b0, arready}, 32'd0);
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    check("t4_rvalid_gone", {31'b0, rvalid}, 32'd0);

    // Same-cycle read and write to one register returns the old value
    axi_write(ENC_REG2, 32'd5, 4'hF);
    araddr = ENC_REG2; arvalid = 1'b1; rready = 1'b1;
    awaddr = ENC_REG2; wdata = 32'd9; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    @(negedge clk);
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    check("t5_rvalid", {31'b0, rvalid}, 32'd1);
    check("t5_bvalid", {31'b0, bvalid}, 32'd1);
    check("t5_old", rdata, 32'd5);
    @(negedge clk);
    rready = 1'b0; bready = 1'b0;
    axi_read(ENC_REG2, rd); check("t5_new", rd, 32'd9);

    // Asynchronous reset while a write response is pending
    awaddr = ENC_REG0; wdata = 32'd7; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    check("t6_bvalid", {31'b0, bvalid}, 32'd1);
    check("t6_reg0", reg_q[0], 32'd7);
    #2 rst = 1'b1;
    #1;
    check("t6_async_bvalid", {31'b0, bvalid}, 32'd0);
    check("t6_async_reg0", reg_q[0], 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t6_no_bvalid", {31'b0, bvalid}, 32'd0);
    axi_read(ENC_REG0, rd); check("t6_rd0", rd, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
